// File: rtl/pi_servo_pkg.sv
// Shared constants, types and saturation limits for the AXI-Stream PI servo.
package pi_servo_pkg;

  localparam int unsigned SHIFT_W       = 6;
  localparam int unsigned ACC_WIDTH_DEF = 48;

  // Signed power-of-two gain exponent.
  typedef logic signed [SHIFT_W-1:0] shexp_t;

  function automatic longint sat_hi(input int unsigned w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int unsigned w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/axis_pi_servo_if.sv
// AXI-Stream channel carrying a data word and a channel number in tuser.
interface axis_pi_servo_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CH_W       = 1
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic [CH_W-1:0]       tuser;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tuser, output tvalid, input tready);
  modport slave  (input tdata, input tuser, input tvalid, output tready);

endinterface

// File: rtl/pi_shift.sv
// Signed bidirectional arithmetic shift: k >= 0 shifts left, k < 0 shifts right by |k|.
module pi_shift
  import pi_servo_pkg::*;
#(
  parameter int unsigned W = 48
) (
  input  logic signed [W-1:0] din,
  input  shexp_t              k,
  output logic signed [W-1:0] dout
);

  logic [SHIFT_W-1:0] mag;

  always_comb begin
    // Unsigned magnitude, so -32 still decodes as a 32-bit shift.
    mag  = k[SHIFT_W-1] ? SHIFT_W'(-k) : SHIFT_W'(k);
    dout = k[SHIFT_W-1] ? (din >>> mag) : (din <<< mag);
  end

endmodule

// File: rtl/axis_pi_servo.sv
// Three-stage multi-channel PI servo on AXI-Stream samples with per-channel integrators.
// Define PI_SAT_EN for saturating integrator/action arithmetic and sticky sat_flag.
module axis_pi_servo
  import pi_servo_pkg::*;
#(
  parameter int unsigned IN_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int unsigned N_CH       = 2,
  localparam int unsigned CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_pi_servo_if.slave             s_axis,
  axis_pi_servo_if.master            m_axis,
  input  logic signed [IN_WIDTH-1:0] setpoint,
  input  shexp_t                     kp,
  input  shexp_t                     ki,
  input  shexp_t                     kg,
  input  logic                       invert,
  input  logic                       hold,
  input  logic                       int_clr,
  output logic [N_CH-1:0]            sat_flag
);

  typedef logic signed [ACC_WIDTH-1:0] acc_t;

  logic adv;

  logic                  v1_q, v2_q, v3_q, m_valid_q;
  logic [CH_W-1:0]       ch1_q, ch2_q, ch3_q, m_user_q;
  acc_t                  err1_q, err2_q, int2_q, sum3_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  acc_t                  integ_q [N_CH];

  logic signed [IN_WIDTH-1:0] pv;
  logic [CH_W-1:0]            ch_d;
  acc_t                       err_d, int_cur, int_sum, int_d;
  acc_t                       sh_p, sh_i, sum_d, sh_g, act;
  logic [DATA_WIDTH-1:0]      out_d;

  // Whole pipeline freezes only while a valid output is refused.
  assign adv           = !(m_valid_q && !m_axis.tready);
  assign s_axis.tready = adv;
  assign m_axis.tvalid = m_valid_q;
  assign m_axis.tdata  = m_data_q;
  assign m_axis.tuser  = m_user_q;

  // S1: error from the top IN_WIDTH bits of the sample.
  always_comb begin
    pv    = $signed(s_axis.tdata[DATA_WIDTH-1 -: IN_WIDTH]);
    err_d = ACC_WIDTH'(setpoint) - ACC_WIDTH'(pv);
    ch_d  = (32'(s_axis.tuser) >= N_CH) ? '0 : s_axis.tuser;
  end

`ifdef PI_SAT_EN
  localparam acc_t SAT_HI = acc_t'(sat_hi(DATA_WIDTH));
  localparam acc_t SAT_LO = acc_t'(sat_lo(DATA_WIDTH));
  logic int_sat, act_sat;
  logic [N_CH-1:0] sat_q;
`endif

  // S2: integrator read-modify-write against the array itself, so back-to-back
  // samples on one channel see each other's update.
  always_comb begin
    int_cur = integ_q[ch1_q];
    int_sum = int_cur + err1_q;
`ifdef PI_SAT_EN
    int_sat = 1'b0;
    if (int_sum > SAT_HI) begin
      int_d   = SAT_HI;
      int_sat = 1'b1;
    end else if (int_sum < SAT_LO) begin
      int_d   = SAT_LO;
      int_sat = 1'b1;
    end else begin
      int_d = int_sum;
    end
    if (hold) int_sat = 1'b0;
`else
    int_d = int_sum;
`endif
    if (hold) int_d = int_cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) integ_q[i] <= '0;
    end else if (int_clr) begin
      for (int i = 0; i < N_CH; i++) integ_q[i] <= '0;
    end else if (adv && v1_q) begin
      integ_q[ch1_q] <= int_d;
    end
  end

  // S3: proportional plus integral terms.
  pi_shift #(.W(ACC_WIDTH)) u_shift_p (.din(err2_q), .k(kp), .dout(sh_p));
  pi_shift #(.W(ACC_WIDTH)) u_shift_i (.din(int2_q), .k(ki), .dout(sh_i));
  assign sum_d = sh_p + sh_i;

  // Output: overall gain, polarity and narrowing to DATA_WIDTH.
  pi_shift #(.W(ACC_WIDTH)) u_shift_g (.din(sum3_q), .k(kg), .dout(sh_g));

  always_comb begin
    act = invert ? -sh_g : sh_g;
`ifdef PI_SAT_EN
    act_sat = 1'b0;
    if (act > SAT_HI) begin
      out_d   = DATA_WIDTH'(SAT_HI);
      act_sat = 1'b1;
    end else if (act < SAT_LO) begin
      out_d   = DATA_WIDTH'(SAT_LO);
      act_sat = 1'b1;
    end else begin
      out_d = act[DATA_WIDTH-1:0];
    end
`else
    out_d = act[DATA_WIDTH-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      m_valid_q <= 1'b0;
      ch1_q     <= '0;
      ch2_q     <= '0;
      ch3_q     <= '0;
      m_user_q  <= '0;
      err1_q    <= '0;
      err2_q    <= '0;
      int2_q    <= '0;
      sum3_q    <= '0;
      m_data_q  <= '0;
    end else if (adv) begin
      v1_q      <= s_axis.tvalid;
      ch1_q     <= ch_d;
      err1_q    <= err_d;
      v2_q      <= v1_q;
      ch2_q     <= ch1_q;
      err2_q    <= err1_q;
      int2_q    <= int_d;
      v3_q      <= v2_q;
      ch3_q     <= ch2_q;
      sum3_q    <= sum_d;
      m_valid_q <= v3_q;
      if (v3_q) begin
        m_data_q <= out_d;
        m_user_q <= ch3_q;
      end
    end
  end

`ifdef PI_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_q <= '0;
    end else if (int_clr) begin
      sat_q <= '0;
    end else if (adv) begin
      if (v1_q && int_sat) sat_q[ch1_q] <= 1'b1;
      if (v3_q && act_sat) sat_q[ch3_q] <= 1'b1;
    end
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = '0;
`endif

endmodule

// File: tb/tb_axis_pi_servo.sv
// Bench for axis_pi_servo: directed steps plus random samples against an arithmetic model.
module tb_axis_pi_servo;
  import pi_servo_pkg::*;

  localparam int unsigned IN_W = 14;
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 48;
  localparam int unsigned NCH  = 2;
  localparam int unsigned CHW  = 1;
  localparam longint DMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint DMIN = -(longint'(1) <<< (DW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_pi_servo_if #(.DATA_WIDTH(DW), .CH_W(CHW)) s_if ();
  axis_pi_servo_if #(.DATA_WIDTH(DW), .CH_W(CHW)) m_if ();

  logic signed [IN_W-1:0] setpoint;
  shexp_t kp, ki, kg;
  logic invert, hold, int_clr;
  logic [NCH-1:0] sat_flag;

  axis_pi_servo #(.IN_WIDTH(IN_W), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .N_CH(NCH)) dut (
    .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if), .setpoint(setpoint),
    .kp(kp), .ki(ki), .kg(kg), .invert(invert), .hold(hold), .int_clr(int_clr),
    .sat_flag(sat_flag)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {logic [DW-1:0] data; logic [CHW-1:0] ch;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  longint integ_m[NCH];
  logic [NCH-1:0] sat_m;
  logic [DW-1:0] last_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference arithmetic: ACC-wide two's complement, shifts as powers of two.
  function automatic longint wrap_acc(input longint x);
    longint r;
    r = x <<< (64 - AW);
    return r >>> (64 - AW);
  endfunction

  function automatic longint ashift(input longint x, input int k);
    longint d, q;
    if (k >= 0) return wrap_acc(x * (longint'(1) << k));
    d = longint'(1) << (-k);
    q = x / d;
    if ((x % d) != 0 && x < 0) q = q - 1;
    return q;
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < NCH; i++) integ_m[i] = 0;
    sat_m = '0;
  endfunction

  function automatic void model_accept(input longint pv, input int ch);
    longint err, acc, sum, act;
    bit sat;
    exp_t e;
    err = longint'(setpoint) - pv;
    sat = 1'b0;
    if (!hold) begin
      acc = integ_m[ch] + err;
`ifdef PI_SAT_EN
      if (acc > DMAX) begin acc = DMAX; sat = 1'b1; end
      else if (acc < DMIN) begin acc = DMIN; sat = 1'b1; end
`else
      acc = wrap_acc(acc);
`endif
      integ_m[ch] = acc;
    end
    sum = wrap_acc(ashift(err, int'(kp)) + ashift(integ_m[ch], int'(ki)));
    act = ashift(sum, int'(kg));
    if (invert) act = wrap_acc(-act);
`ifdef PI_SAT_EN
    if (act > DMAX) begin act = DMAX; sat = 1'b1; end
    else if (act < DMIN) begin act = DMIN; sat = 1'b1; end
`endif
    if (sat) sat_m[ch] = 1'b1;
    e.data = act[DW-1:0];
    e.ch   = CHW'(ch);
    exp_q.push_back(e);
  endfunction

  // Called at a negedge; returns at the negedge after the sample is taken.
  task automatic send(input logic [IN_W-1:0] pv, input int ch);
    int budget = 100;
    s_if.tdata  = {pv, 18'($urandom)};
    s_if.tuser  = CHW'(ch);
    s_if.tvalid = 1'b1;
    while (!s_if.tready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("send_timeout", 64'(s_if.tready), 64'(1));
    model_accept(longint'($signed(pv)), ch);
    @(negedge clk);
  endtask

  task automatic idle();
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    int budget = 200;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) check("drain_timeout", 64'(exp_q.size()), 64'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_clr();
    int_clr = 1'b1;
    @(negedge clk);
    int_clr = 1'b0;
    clear_model();
  endtask

  task automatic set_gains(input int p, input int i, input int g);
    kp = shexp_t'(p);
    ki = shexp_t'(i);
    kg = shexp_t'(g);
  endtask

  // Output scoreboard; transfer happens at the following posedge.
  always @(negedge clk) begin
    if (!rst && m_if.tvalid && m_if.tready) begin
      check("out_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        last_out = m_if.tdata;
        check("out_data", 64'(m_if.tdata), 64'(mon_e.data));
        check("out_ch", 64'(m_if.tuser), 64'(mon_e.ch));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.tdata = '0; s_if.tuser = '0; s_if.tvalid = 1'b0;
    m_if.tready = 1'b1;
    setpoint = '0; invert = 1'b0; hold = 1'b0; int_clr = 1'b0;
    set_gains(0, -31, 0);
    clear_model();
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'(0));
    check("rst_m_tdata", 64'(m_if.tdata), 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_m_tuser", 64'(m_if.tuser), 64'(0));
    check("rst_sat_flag", 64'(sat_flag), 64'(0));
    check("rst_s_tready", 64'(s_if.tready), 64'(1));

    // Single sample, latency of three edges, value 100.
    send(-14'sd100, 0);
    idle();
    @(negedge clk); check("lat_n1", 64'(m_if.tvalid), 64'(0));
    @(negedge clk); check("lat_n2", 64'(m_if.tvalid), 64'(0));
    @(negedge clk); check("lat_n3", 64'(m_if.tvalid), 64'(1));
    check("lat_n3_data", 64'(m_if.tdata), 64'(100));
    drain();

    // Pure integrator readout: 100, 200, 300, 400 on ch0; ch1 untouched.
    pulse_clr();
    set_gains(-31, 0, 0);
    repeat (4) send(-14'sd100, 0);
    send(14'sd0, 1);
    idle();
    drain();
    check("acc_ch0_400", 64'(integ_m[0]), 64'(400));
    check("acc_ch1_last", 64'(last_out), 64'(0));

    // Backpressure mid-stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(IN_W'($urandom_range(0, 400)), i % 2);
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #2 m_if.tready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_s_tready", 64'(s_if.tready), 64'(0));
          check("stall_m_tvalid", 64'(m_if.tvalid), 64'(1));
        end
        @(posedge clk);
        #2 m_if.tready = 1'b1;
      end
    join
    drain();
    check("stall_queue_empty", 64'(exp_q.size()), 64'(0));

    // int_clr on the same edge as a ch1 integrator update.
    set_gains(0, 0, 0);
    setpoint = 14'sd50;
    send(14'sd0, 1);
    idle();
    pulse_clr();
    drain();
    set_gains(-31, 0, 0);
    setpoint = 14'sd7;
    send(14'sd0, 1);
    idle();
    drain();
    check("clr_ch1_out", 64'(last_out), 64'(7));

    // Hold freezes the integrator; invert negates.
    hold = 1'b1;
    set_gains(0, 0, 0);
    send(14'sd3, 0);
    send(14'sd3, 1);
    idle();
    drain();
    hold = 1'b0;
    invert = 1'b1;
    send(-14'sd20, 0);
    idle();
    drain();
    invert = 1'b0;

    // Large error, high gain: clamps or wraps by build.
    pulse_clr();
    setpoint = 14'sd8191;
    set_gains(20, 0, 10);
    send(14'sd0, 0);
    idle();
    drain();
`ifdef PI_SAT_EN
    check("big_out", 64'(last_out), 64'(32'h7FFF_FFFF));
    check("big_sat0", 64'(sat_flag[0]), 64'(1));
`else
    check("big_out", 64'(last_out), 64'(32'hC07F_FC00));
    check("big_sat0", 64'(sat_flag[0]), 64'(0));
`endif
    check("big_sat_model", 64'(sat_flag), 64'(sat_m));

    // Random batches with random gains, channels and gaps.
    for (int b = 0; b < 4; b++) begin
      set_gains(int'($urandom_range(0, 62)) - 31, int'($urandom_range(0, 62)) - 31,
                int'($urandom_range(0, 62)) - 31);
      invert   = 1'($urandom);
      setpoint = IN_W'($urandom);
      for (int i = 0; i < 15; i++) begin
        send(IN_W'($urandom), int'($urandom_range(0, NCH - 1)));
        if ($urandom_range(0, 3) == 0) begin
          idle();
          @(negedge clk);
        end
      end
      idle();
      drain();
      check("rand_sat_flag", 64'(sat_flag), 64'(sat_m));
    end

    // Reset with two samples in flight.
    invert = 1'b0;
    set_gains(0, 0, 0);
    setpoint = 14'sd30;
    send(14'sd0, 0);
    send(14'sd0, 0);
    idle();
    rst = 1'b1;
    exp_q.delete();
    clear_model();
    repeat (3) begin
      @(negedge clk);
      check("rst_flight_tvalid", 64'(m_if.tvalid), 64'(0));
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_tvalid", 64'(m_if.tvalid), 64'(0));
    end
    check("post_rst_sat", 64'(sat_flag), 64'(0));
    send(14'sd0, 0);
    idle();
    drain();
    check("post_rst_out", 64'(last_out), 64'(60));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_pi_servo.md
AXIS_PI_SERVO -- requirements
Module: axis_pi_servo

Interface
REQ-001 Parameter IN_WIDTH, default 14, meaning: significant signed bits taken from the top of s_axis_tdata.
REQ-002 Parameter DATA_WIDTH, default 32, meaning: AXIS tdata width, in and out.
REQ-003 Parameter ACC_WIDTH, default 48, meaning: internal signed error/integrator/sum width (ACC_WIDTH >= DATA_WIDTH + 8).
REQ-004 Parameter N_CH, default 2, meaning: independent interleaved channels (1..16); CH_W = max(1, clog2(N_CH)).
REQ-005 clk  in  1  clock; reset rst, asynchronous, active-high; clock clk.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 s_axis_tdata/tuser/tvalid/tready  in/in/in/out  DATA_WIDTH/CH_W/1/1  process-value sample; tuser = channel.
REQ-008 m_axis_tdata/tuser/tvalid/tready  out/out/out/in  DATA_WIDTH/CH_W/1/1  actuator word; tuser = channel.
REQ-009 setpoint  in  IN_WIDTH  signed setpoint, shared by all channels.
REQ-010 kp, ki, kg  in  6 each  signed power-of-two shift exponents, range -31..+31.
REQ-011 invert  in  1  negate the loop output when 1.
REQ-012 hold, int_clr  in  1 each  freeze integrator; clear all integrators.
REQ-013 sat_flag  out  N_CH  per-channel sticky saturation status.

Function
REQ-014 Transfer SHALL occur when tvalid && tready on the respective port.
REQ-015 Pipeline SHALL be 3 stages; accepted sample at edge N SHALL appear on m_axis at edge N+3 with no backpressure.
REQ-016 S1: PV = s_axis_tdata[DATA_WIDTH-1 -: IN_WIDTH]; error = sext(setpoint) - sext(PV) in ACC_WIDTH.
REQ-017 S2: integrator[ch] <= integrator[ch] + error unless hold=1; read-modify-write in the same stage, so back-to-back same-channel samples SHALL accumulate without a hazard.
REQ-018 S3: sum = shift(error,kp) + shift(integrator,ki); action = shift(sum,kg), negated when invert=1; positive exponent = arithmetic left shift, negative = arithmetic right shift by |k|.
REQ-019 Output word SHALL be action bits [DATA_WIDTH-1:0] after narrowing per REQ-028/029.
REQ-020 Stall rule: the whole pipeline SHALL freeze while m_axis_tvalid && !m_axis_tready; s_axis_tready = !(m_axis_tvalid && !m_axis_tready).
REQ-021 Pipeline bubbles SHALL propagate; m_axis_tvalid SHALL be high only for real samples.
REQ-022 Gain, setpoint and invert SHALL be sampled in the stage that uses them; mid-stream changes apply to the next sample reaching that stage.
REQ-023 int_clr SHALL zero every integrator and sat_flag on the next edge and take priority over a simultaneous S2 update.
REQ-024 tuser >= N_CH SHALL be treated as channel 0.

Reset
REQ-025 rst SHALL clear all integrators, pipeline valids, m_axis_tdata, m_axis_tuser and sat_flag to 0; m_axis_tvalid SHALL be 0 during and after reset until a new sample has traversed.
REQ-026 A sample in flight when rst asserts SHALL be discarded, not emitted.

Configuration
REQ-027 The macro PI_SAT_EN SHALL select saturating arithmetic.
REQ-028 With PI_SAT_EN: the integrator SHALL clamp to the signed DATA_WIDTH range (anti-windup); action SHALL clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; either clamp SHALL set sat_flag[ch].
REQ-029 Without PI_SAT_EN: integrator and action SHALL wrap in two's complement (action truncated to the low DATA_WIDTH bits); sat_flag SHALL be tied to 0.

Structure
REQ-030 Package pi_servo_pkg SHALL hold the shift-exponent width constant (6), the ACC_WIDTH default and the saturation-limit functions.
REQ-031 Sub-module pi_shift SHALL implement the signed bidirectional arithmetic shift, instantiated 3 times.

Verification
REQ-032 IN=14, setpoint=0, PV=-100 (tdata=0xFE70_0000), kp=0, ki=-31, kg=0, invert=0, ch0 -> tdata=100 at N+3.
REQ-033 Same stimulus ×4 on ch0, ki=0, kp=-31 -> integrator 100, 200, 300, 400; outputs 100, 200, 300, 400; ch1 integrator stays 0.
REQ-034 Hold m_axis_tready=0 for 5 cycles mid-stream -> s_axis_tready=0, no sample lost or duplicated, order preserved.
REQ-035 PI_SAT_EN, error=+8191, ki=0, kp=20, kg=10 -> tdata=0x7FFF_FFFF and sat_flag[0]=1; without the macro -> wrapped low 32 bits.
REQ-036 rst asserted with 2 samples in flight -> no m_axis_tvalid; the next sample yields an output built from a zero integrator.
REQ-037 int_clr pulsed coincident with an S2 update on ch1 -> integrator[ch1]=0 afterwards.
